// File: rtl/rvv_backend_alu_rs_fifo.sv
// rtl/rvv_backend_alu_rs_fifo.sv - multi-port ALU reservation-station FIFO
//
// Purpose: circular FIFO between dispatch (up to NUM_PUSH writes per cycle)
// and the ALUs (up to NUM_POP retires per cycle). Entries are read
// combinationally at the read pointer. Status flags depend only on the
// registered count.
//
// Ports:
//   clk                     - clock, all state updates on rising edge
//   rst                     - synchronous active-high reset
//   push_dp2rs              - per-port write request, thermometer from bit 0
//   data_dp2rs              - per-port write data
//   fifo_full_rs2dp         - count == DEPTH
//   fifo_almost_full_rs2dp  - bit j: fewer than j+1 free entries
//   pop_ex2rs               - per-port retire request, thermometer from bit 0
//   alu_uop_rs2ex           - entry at read pointer + i
//   fifo_empty_rs2ex        - count == 0
//   fifo_almost_empty_rs2ex - bit i: count <= i
module rvv_backend_alu_rs_fifo #(
    parameter int DEPTH    = 8,
    parameter int NUM_PUSH = 2,
    parameter int NUM_POP  = 2,
    parameter int DW       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PUSH-1:0] push_dp2rs,
    input  logic [DW-1:0]       data_dp2rs [NUM_PUSH],
    output logic                fifo_full_rs2dp,
    output logic [NUM_PUSH-1:1] fifo_almost_full_rs2dp,
    input  logic [NUM_POP-1:0]  pop_ex2rs,
    output logic [DW-1:0]       alu_uop_rs2ex [NUM_POP],
    output logic                fifo_empty_rs2ex,
    output logic [NUM_POP-1:1]  fifo_almost_empty_rs2ex
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]       rptr;
    logic [AW-1:0]       wptr;
    logic [CW-1:0]       count;
    logic [DW-1:0]       mem [DEPTH];

    logic [NUM_PUSH-1:0] push_acc;
    logic [NUM_POP-1:0]  pop_acc;
    logic [CW-1:0]       num_push;
    logic [CW-1:0]       num_pop;
    logic                push_chain;
    logic                pop_chain;

    // Acceptance uses the current count only; a same-cycle pop never frees
    // room for a push, which keeps the full path free of pop timing.
    always_comb begin
        push_acc   = '0;
        pop_acc    = '0;
        num_push   = '0;
        num_pop    = '0;
        push_chain = 1'b1;
        pop_chain  = 1'b1;
        for (int j = 0; j < NUM_PUSH; j++) begin
            push_chain  = push_chain & push_dp2rs[j];
            push_acc[j] = push_chain && ((int'(count) + j) < DEPTH);
            if (push_acc[j]) begin
                num_push = num_push + CW'(1);
            end
        end
        for (int i = 0; i < NUM_POP; i++) begin
            pop_chain  = pop_chain & pop_ex2rs[i];
            pop_acc[i] = pop_chain && (i < int'(count));
            if (pop_acc[i]) begin
                num_pop = num_pop + CW'(1);
            end
        end
    end

    // Storage is not reset; reset only blocks writes in its own cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            for (int j = 0; j < NUM_PUSH; j++) begin
                if (push_acc[j]) begin
                    mem[wptr + AW'(j)] <= data_dp2rs[j];
                end
            end
            wptr  <= wptr + AW'(num_push);
            rptr  <= rptr + AW'(num_pop);
            count <= count + num_push - num_pop;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_POP; i++) begin
            alu_uop_rs2ex[i] = mem[rptr + AW'(i)];
        end
    end

    always_comb begin
        fifo_full_rs2dp  = (count == CW'(DEPTH));
        fifo_empty_rs2ex = (count == '0);
        fifo_almost_full_rs2dp  = '0;
        fifo_almost_empty_rs2ex = '0;
        for (int j = 1; j < NUM_PUSH; j++) begin
            fifo_almost_full_rs2dp[j] = (count > CW'(DEPTH - 1 - j));
        end
        for (int i = 1; i < NUM_POP; i++) begin
            fifo_almost_empty_rs2ex[i] = (count <= CW'(i));
        end
    end

    push_thermometer: assert property (@(posedge clk) disable iff (rst)
        ((push_dp2rs & (push_dp2rs + NUM_PUSH'(1))) == '0))
        else $error("rs_fifo: non-thermometer push vector %b", push_dp2rs);

    pop_thermometer: assert property (@(posedge clk) disable iff (rst)
        ((pop_ex2rs & (pop_ex2rs + NUM_POP'(1))) == '0))
        else $error("rs_fifo: non-thermometer pop vector %b", pop_ex2rs);

    // Dropped pushes and ignored pops are legal flow control, so these are
    // reported as warnings rather than errors.
    push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push_dp2rs[0] && fifo_full_rs2dp))
        else $warning("rs_fifo: push while full, dropped");

    pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop_ex2rs[0] && fifo_empty_rs2ex))
        else $warning("rs_fifo: pop while empty, ignored");

endmodule

// File: doc/rvv_backend_alu_rs_fifo.md
RVV_BACKEND_ALU_RS_FIFO -- requirements
Module: rvv_backend_alu_rs_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries; power of two; DEPTH >= max(NUM_PUSH, NUM_POP).
REQ-002 SHALL have parameter NUM_PUSH, default 2: dispatch write ports.
REQ-003 SHALL have parameter NUM_POP, default `NUM_ALU (2): ALU read ports.
REQ-004 SHALL have parameter DW, default $bits(ALU_RS_t): entry width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port push_dp2rs, input, NUM_PUSH: write request per port; thermometer-coded from bit 0.
REQ-008 SHALL have port data_dp2rs, input, NUM_PUSH x DW: write data per port.
REQ-009 SHALL have port fifo_full_rs2dp, output, 1: count == DEPTH.
REQ-010 SHALL have port fifo_almost_full_rs2dp, output, NUM_PUSH-1 (bits 1..NUM_PUSH-1): bit j set when count > DEPTH-1-j, i.e. fewer than j+1 free entries.
REQ-011 SHALL have port pop_ex2rs, input, NUM_POP: read-retire request per port from ALU; thermometer-coded.
REQ-012 SHALL have port alu_uop_rs2ex, output, NUM_POP x DW: entry at read pointer + i.
REQ-013 SHALL have port fifo_empty_rs2ex, output, 1: count == 0.
REQ-014 SHALL have port fifo_almost_empty_rs2ex, output, NUM_POP-1 (bits 1..NUM_POP-1): bit i set when count <= i.

Function
REQ-015 SHALL hold state: rptr, wptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), storage array of DEPTH x DW.
REQ-016 SHALL accept push_dp2rs[j] only when push_dp2rs[j-1:0] all set and count + j < DEPTH (current-cycle count, same-cycle pops not credited); unaccepted pushes dropped.
REQ-017 SHALL write accepted push j to storage[wptr + j]; wptr advances by number of accepted pushes.
REQ-018 SHALL accept pop_ex2rs[i] only when pop_ex2rs[i-1:0] all set and i < count; unaccepted pops ignored.
REQ-019 SHALL advance rptr by number of accepted pops; popped entries not cleared.
REQ-020 SHALL update count_next = count + accepted_pushes - accepted_pops in the same cycle for simultaneous push and pop.
REQ-021 SHALL drive alu_uop_rs2ex[i] combinationally from storage[rptr + i] with zero-cycle read latency; value undefined when i >= count.
REQ-022 SHALL derive all status outputs combinationally from registered count only (no input-to-output combinational path from push or pop).
REQ-023 SHALL make a pushed entry visible on alu_uop_rs2ex the cycle after the push.
REQ-024 SHALL preserve FIFO order across pointer wrap-around and across multi-port push/pop.
REQ-025 SHALL flag non-thermometer push or pop vectors, push when full, and pop when empty via SVA assertions (simulation only; no RTL effect beyond REQ-016/018).

Reset
REQ-026 SHALL, while rst is high at a clock edge, set rptr = 0, wptr = 0, count = 0; storage not reset.
REQ-027 SHALL after reset drive fifo_empty_rs2ex = 1, fifo_almost_empty_rs2ex all 1, fifo_full_rs2dp = 0, fifo_almost_full_rs2dp all 0.
REQ-028 SHALL let reset override any same-cycle push or pop; pending entries discarded.

Verification (DEPTH=8, NUM_PUSH=2, NUM_POP=2)
REQ-029 SHALL cover: reset, push_dp2rs=2'b11 data A,B -> next cycle empty=0, almost_empty[1]=0, alu_uop[0]=A, alu_uop[1]=B.
REQ-030 SHALL cover: one entry held, pop=2'b11 -> only entry 0 retired, count 0, empty=1.
REQ-031 SHALL cover: fill to 7 -> almost_full[1]=1, full=0; push=2'b11 -> only port 0 written, count 8, full=1.
REQ-032 SHALL cover: count 8, push=2'b11 with pop=2'b11 -> pushes dropped, count 6, order intact.
REQ-033 SHALL cover: 20 cycles random push/pop against a reference queue -> wrap-around data and order match, count == model.
REQ-034 SHALL cover: count 5, rst high with push=2'b11 -> next cycle count 0, empty=1, full=0.
